// File: rtl/ysyx_23060187_ifu.sv
// Instruction fetch unit: one fetch in flight, re-armed by the commit PC-update pulse.
// Faults (misaligned PC, bus error, timeout) are delivered to decode with a NOP instead of stalling.
module ysyx_23060187_ifu #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INST       = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_upd,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [1:0]  inst_fault
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam logic [1:0] F_NONE  = 2'd0;
  localparam logic [1:0] F_ALIGN = 2'd1;
  localparam logic [1:0] F_BUS   = 2'd2;
  localparam logic [1:0] F_TMO   = 2'd3;

  // Timer counts from 0 on the first AR cycle, so this value marks the last allowed cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic        go_pending_q, go_pending_d;
  logic        drain_q, drain_d;
  logic [7:0]  timer_q, timer_d;
  logic [31:0] araddr_q, araddr_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [1:0]  inst_fault_q, inst_fault_d;
  logic        timed_out;

  always_comb begin
    state_d      = state_q;
    go_pending_d = go_pending_q;
    drain_d      = drain_q;
    timer_d      = timer_q;
    araddr_d     = araddr_q;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    inst_fault_d = inst_fault_q;
    timed_out    = (timer_q >= TMO_LAST);

    if (pc_upd) go_pending_d = 1'b1;

    // A response left over from a timed-out read is swallowed outside R.
    if (drain_q && rready_q && rvalid && (state_q != S_R)) drain_d = 1'b0;

    if ((state_q == S_AR) || (state_q == S_R)) begin
      if (timer_q != 8'hFF) timer_d = timer_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if ((go_pending_q || pc_upd) && !drain_q) begin
          go_pending_d = 1'b0;
          araddr_d     = pc_in;
          inst_pc_d    = pc_in;
          if (pc_in[1:0] != 2'b00) begin
            state_d      = S_OUT;
            inst_out_d   = NOP_INST;
            inst_fault_d = F_ALIGN;
            inst_valid_d = 1'b1;
          end else begin
            state_d = S_AR;
            timer_d = 8'd0;
          end
        end
      end
      S_AR: begin
        if (arvalid_q && arready) begin
          state_d = S_R;
        end else if (timed_out) begin
          state_d      = S_OUT;
          inst_out_d   = NOP_INST;
          inst_fault_d = F_TMO;
          inst_valid_d = 1'b1;
        end
      end
      S_R: begin
        if (rvalid) begin
          state_d      = S_OUT;
          inst_out_d   = (rresp == 2'b00) ? rdata : NOP_INST;
          inst_fault_d = (rresp == 2'b00) ? F_NONE : F_BUS;
          inst_valid_d = 1'b1;
        end else if (timed_out) begin
          state_d      = S_OUT;
          inst_out_d   = NOP_INST;
          inst_fault_d = F_TMO;
          inst_valid_d = 1'b1;
          drain_d      = 1'b1;
        end
      end
      default: begin
        if (inst_ready) begin
          state_d      = S_IDLE;
          inst_valid_d = 1'b0;
        end
      end
    endcase

    arvalid_d = (state_d == S_AR);
    rready_d  = (state_d == S_R) || drain_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      go_pending_q <= 1'b1;
      drain_q      <= 1'b0;
      timer_q      <= 8'd0;
      araddr_q     <= 32'd0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      inst_out_q   <= 32'd0;
      inst_pc_q    <= 32'd0;
      inst_valid_q <= 1'b0;
      inst_fault_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      go_pending_q <= go_pending_d;
      drain_q      <= drain_d;
      timer_q      <= timer_d;
      araddr_q     <= araddr_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      inst_fault_q <= inst_fault_d;
    end
  end

  assign araddr     = araddr_q;
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;
  assign inst_out   = inst_out_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign inst_fault = inst_fault_q;

endmodule

// File: tb/tb_ysyx_23060187_ifu.sv
// Directed bench for the fetch unit: nominal fetch, decode backpressure, faults, drain and reset.
module tb_ysyx_23060187_ifu;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_upd;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [1:0]  inst_fault;

  int errs   = 0;
  int checks = 0;

  ysyx_23060187_ifu #(.TIMEOUT_CYCLES(4), .NOP_INST(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_upd(pc_upd),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst_out(inst_out), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_fault(inst_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_araddr"}, araddr, 32'd0);
    chk({tag, "_arvalid"}, {31'd0, arvalid}, 32'd0);
    chk({tag, "_rready"}, {31'd0, rready}, 32'd0);
    chk({tag, "_inst_out"}, inst_out, 32'd0);
    chk({tag, "_inst_pc"}, inst_pc, 32'd0);
    chk({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, "_inst_fault"}, {30'd0, inst_fault}, 32'd0);
  endtask

  task automatic chk_inst(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                          input logic [1:0] flt);
    chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
    chk({tag, "_inst"}, inst_out, ins);
    chk({tag, "_pc"}, inst_pc, pc);
    chk({tag, "_fault"}, {30'd0, inst_fault}, {30'd0, flt});
  endtask

  initial begin
    rst = 1'b1; pc_in = 32'h8000_0000; pc_upd = 1'b0; arready = 1'b1;
    rdata = 32'd0; rresp = 2'd0; rvalid = 1'b0; inst_ready = 1'b0;
    #1 rst = 1'b0;
    step(); step();
    chk_zero("reset");

    // Nominal fetch after reset release: arvalid at cycle 1, rready at 2, inst_valid at 3.
    rst = 1'b1;
    step();
    chk("c1_arvalid", {31'd0, arvalid}, 32'd1);
    chk("c1_araddr", araddr, 32'h8000_0000);
    chk("c1_inst_valid", {31'd0, inst_valid}, 32'd0);
    step();
    chk("c2_rready", {31'd0, rready}, 32'd1);
    chk("c2_arvalid", {31'd0, arvalid}, 32'd0);
    rvalid = 1'b1; rdata = 32'h0010_0093; rresp = 2'd0;
    step();
    rvalid = 1'b0; rdata = 32'd0;
    chk_inst("c3", 32'h0010_0093, 32'h8000_0000, 2'd0);
    chk("c3_rready", {31'd0, rready}, 32'd0);

    // Decode backpressure holds the output stable.
    for (int i = 0; i < 5; i++) begin
      step();
      chk_inst("hold", 32'h0010_0093, 32'h8000_0000, 2'd0);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("post_hs_valid", {31'd0, inst_valid}, 32'd0);
    step(); step(); step();
    chk("no_refetch_arvalid", {31'd0, arvalid}, 32'd0);

    // Misaligned PC faults without touching the bus.
    pc_in = 32'h8000_0002; pc_upd = 1'b1;
    step();
    pc_upd = 1'b0;
    chk("mis_arvalid", {31'd0, arvalid}, 32'd0);
    chk_inst("mis", 32'h0000_0013, 32'h8000_0002, 2'd1);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("mis_hs_valid", {31'd0, inst_valid}, 32'd0);

    // Bus error returns NOP with fault 2.
    pc_in = 32'h8000_0004; pc_upd = 1'b1;
    step();
    pc_upd = 1'b0;
    chk("berr_arvalid", {31'd0, arvalid}, 32'd1);
    chk("berr_araddr", araddr, 32'h8000_0004);
    step();
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'd2;
    step();
    rvalid = 1'b0; rresp = 2'd0;
    chk_inst("berr", 32'h0000_0013, 32'h8000_0004, 2'd2);

    // Handshake and pc_upd in the same cycle: IDLE for one cycle, then fetch.
    pc_in = 32'h8000_0008; inst_ready = 1'b1; pc_upd = 1'b1;
    step();
    inst_ready = 1'b0; pc_upd = 1'b0;
    chk("simul_valid", {31'd0, inst_valid}, 32'd0);
    chk("simul_arvalid0", {31'd0, arvalid}, 32'd0);
    step();
    chk("simul_arvalid1", {31'd0, arvalid}, 32'd1);
    chk("simul_araddr", araddr, 32'h8000_0008);

    // Timeout with 4 cycles in AR+R: 1 AR cycle, 3 R cycles, then OUT.
    step(); step(); step();
    chk("tmo_rready_wait", {31'd0, rready}, 32'd1);
    chk("tmo_not_yet", {31'd0, inst_valid}, 32'd0);
    step();
    chk_inst("tmo", 32'h0000_0013, 32'h8000_0008, 2'd3);
    chk("tmo_drain_rready", {31'd0, rready}, 32'd1);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("tmo_idle_rready", {31'd0, rready}, 32'd1);
    pc_in = 32'h8000_000C; pc_upd = 1'b1;
    step();
    pc_upd = 1'b0;
    chk("drain_blocks_ar", {31'd0, arvalid}, 32'd0);
    rvalid = 1'b1; rdata = 32'h1234_5678;
    step();
    rvalid = 1'b0; rdata = 32'd0;
    chk("drain_done_rready", {31'd0, rready}, 32'd0);
    chk("drain_no_valid", {31'd0, inst_valid}, 32'd0);
    chk("drain_done_arvalid", {31'd0, arvalid}, 32'd0);
    step();
    chk("after_drain_arvalid", {31'd0, arvalid}, 32'd1);
    chk("after_drain_araddr", araddr, 32'h8000_000C);
    step();
    rvalid = 1'b1; rdata = 32'h0020_0113;
    step();
    rvalid = 1'b0; rdata = 32'd0;
    chk_inst("after_drain", 32'h0020_0113, 32'h8000_000C, 2'd0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;

    // Reset in R abandons the read; release refetches the current PC.
    pc_in = 32'h8000_0010; pc_upd = 1'b1;
    step();
    pc_upd = 1'b0;
    step();
    chk("rst_in_r_rready", {31'd0, rready}, 32'd1);
    rst = 1'b0;
    #1;
    chk_zero("rst_mid");
    step();
    chk_zero("rst_hold");
    rst = 1'b1;
    step();
    chk("rst_refetch_arvalid", {31'd0, arvalid}, 32'd1);
    chk("rst_refetch_araddr", araddr, 32'h8000_0010);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
